cache_mem_ctrl: RTL and testbench

// Parametrised N-port, direct-mapped, write-back data cache controller.
// It sits between the superscalar MEM stage and a line-wide main-memory handshake port.
// It generalises the fixed dual-port cache + memory pair. New features:
//   - NPORTS issue slots.
//   - A miss FSM with stall.
//   - A req/ack memory interface with variable latency.
//   - Hit and miss counters.

---
 rtl/cache_pkg.sv | 39 +++
 rtl/cache_tag_store.sv | 50 +++++
 rtl/cache_mem_ctrl.sv | 159 +++++++++++++++
 tb/tb_cache_mem_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and address helpers for the N-port write-back data cache.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        FILL   = 2'd2,
        REFILL = 2'd3
    } state_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_WPL    = 4;
    localparam int DEF_NSETS  = 256;

    localparam int LINE_W = DEF_DATA_W * DEF_WPL;
    localparam int OFF_W  = $clog2(DEF_WPL);
    localparam int IDX_W  = $clog2(DEF_NSETS);
    localparam int TAG_W  = DEF_ADDR_W - IDX_W - OFF_W - 2;

    // Field helpers take widths explicitly so any module configuration can reuse them.
    function automatic logic [63:0] addr_field(input logic [63:0] a, input int lsb, input int w);
        return (a >> lsb) & ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_off(input logic [63:0] a, input int off_w);
        return addr_field(a, 2, off_w);
    endfunction

    function automatic logic [63:0] addr_idx(input logic [63:0] a, input int off_w, input int idx_w);
        return addr_field(a, off_w + 2, idx_w);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] a, input int off_w, input int idx_w,
                                             input int tag_w);
        return addr_field(a, off_w + idx_w + 2, tag_w);
    endfunction

endpackage

// File: rtl/cache_tag_store.sv
// Tag/valid/dirty array: NPORTS combinational lookups, per-slot dirty set, one fill update port.
module cache_tag_store
    import cache_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int NSETS  = DEF_NSETS,
    parameter int SET_W  = IDX_W,
    parameter int TAGS_W = TAG_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NPORTS-1:0][SET_W-1:0]   lk_idx_i,
    output logic [NPORTS-1:0][TAGS_W-1:0]  lk_tag_o,
    output logic [NPORTS-1:0]              lk_valid_o,
    output logic [NPORTS-1:0]              lk_dirty_o,
    input  logic [NPORTS-1:0]              set_dirty_i,
    input  logic                           upd_en_i,
    input  logic [SET_W-1:0]               upd_idx_i,
    input  logic [TAGS_W-1:0]              upd_tag_i
);

    logic [TAGS_W-1:0] tag_q [NSETS];
    logic [NSETS-1:0]  valid_q;
    logic [NSETS-1:0]  dirty_q;

    for (genvar p = 0; p < NPORTS; p++) begin : g_lk
        assign lk_tag_o[p]   = tag_q[lk_idx_i[p]];
        assign lk_valid_o[p] = valid_q[lk_idx_i[p]];
        assign lk_dirty_o[p] = dirty_q[lk_idx_i[p]];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++)
                if (set_dirty_i[p]) dirty_q[lk_idx_i[p]] <= 1'b1;
            if (upd_en_i) begin
                valid_q[upd_idx_i] <= 1'b1;
                dirty_q[upd_idx_i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (upd_en_i) tag_q[upd_idx_i] <= upd_tag_i;
    end

endmodule

// File: rtl/cache_mem_ctrl.sv
// N-port direct-mapped write-back cache: data array, miss FSM and line-wide req/ack memory port.
module cache_mem_ctrl
    import cache_pkg::*;
#(
    parameter int NPORTS = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int WPL    = DEF_WPL,
    parameter int NSETS  = DEF_NSETS,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NPORTS-1:0]        re,
    input  logic [NPORTS-1:0]        we,
    input  logic [NPORTS*ADDR_W-1:0] addr,
    input  logic [NPORTS*DATA_W-1:0] wdata,
    output logic [NPORTS*DATA_W-1:0] rdata,
    output logic [NPORTS-1:0]        hit,
    output logic [NPORTS-1:0]        miss,
    output logic                     stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W*WPL-1:0]    mem_wline,
    input  logic                     mem_ack,
    input  logic [DATA_W*WPL-1:0]    mem_rline,
    output logic [CNT_W-1:0]         hit_cnt,
    output logic [CNT_W-1:0]         miss_cnt
);

    localparam int LINE_BITS = DATA_W * WPL;
    localparam int OFFS_W    = $clog2(WPL);
    localparam int SET_W     = $clog2(NSETS);
    localparam int TAGS_W    = ADDR_W - SET_W - OFFS_W - 2;

    logic [NPORTS-1:0][SET_W-1:0]  s_idx;
    logic [NPORTS-1:0][TAGS_W-1:0] s_tag, lk_tag;
    logic [NPORTS-1:0][OFFS_W-1:0] s_off;
    logic [NPORTS-1:0]             lk_valid, lk_dirty, set_dirty;

    logic [LINE_BITS-1:0] data_q [NSETS];

    state_e            state_q, state_d;
    logic [TAGS_W-1:0] mtag_q, mtag_d, vtag_q, vtag_d;
    logic [SET_W-1:0]  midx_q, midx_d;
    logic [CNT_W-1:0]  hit_cnt_q, miss_cnt_q;
    logic              fill_done;

    logic [TAGS_W-1:0] pick_tag, pick_vtag;
    logic [SET_W-1:0]  pick_idx;
    logic              pick_wb;

    for (genvar p = 0; p < NPORTS; p++) begin : g_slot
        logic [ADDR_W-1:0]    a;
        logic [LINE_BITS-1:0] line;
        assign a        = addr[p*ADDR_W +: ADDR_W];
        assign s_off[p] = OFFS_W'(addr_off(64'(a), OFFS_W));
        assign s_idx[p] = SET_W'(addr_idx(64'(a), OFFS_W, SET_W));
        assign s_tag[p] = TAGS_W'(addr_tag(64'(a), OFFS_W, SET_W, TAGS_W));
        assign line     = data_q[s_idx[p]];
        assign rdata[p*DATA_W +: DATA_W] = line[s_off[p]*DATA_W +: DATA_W];
        assign hit[p]       = (re[p] | we[p]) & lk_valid[p] & (lk_tag[p] == s_tag[p]);
        assign miss[p]      = (re[p] | we[p]) & ~hit[p];
        assign set_dirty[p] = we[p] & hit[p] & ~stall;
    end

    cache_tag_store #(
        .NPORTS (NPORTS),
        .NSETS  (NSETS),
        .SET_W  (SET_W),
        .TAGS_W (TAGS_W)
    ) u_tags (
        .clk         (clk),
        .reset       (reset),
        .lk_idx_i    (s_idx),
        .lk_tag_o    (lk_tag),
        .lk_valid_o  (lk_valid),
        .lk_dirty_o  (lk_dirty),
        .set_dirty_i (set_dirty),
        .upd_en_i    (fill_done),
        .upd_idx_i   (midx_q),
        .upd_tag_i   (mtag_q)
    );

    // Any miss freezes every slot, so hitting writes in the same cycle wait too.
    assign stall     = (|miss) | (state_q != IDLE);
    assign fill_done = (state_q == FILL) & mem_ack;
    assign mem_req   = (state_q == WB) | (state_q == FILL);
    assign mem_we    = (state_q == WB);
    assign mem_addr  = {(state_q == WB) ? vtag_q : mtag_q, midx_q, {(OFFS_W+2){1'b0}}};
    assign mem_wline = data_q[midx_q];
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

    always_comb begin
        pick_tag  = '0;
        pick_vtag = '0;
        pick_idx  = '0;
        pick_wb   = 1'b0;
        // Descending scan leaves the oldest missing slot selected.
        for (int p = NPORTS - 1; p >= 0; p--) begin
            if (miss[p]) begin
                pick_tag  = s_tag[p];
                pick_idx  = s_idx[p];
                pick_vtag = lk_tag[p];
                pick_wb   = lk_valid[p] & lk_dirty[p];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mtag_d  = mtag_q;
        vtag_d  = vtag_q;
        midx_d  = midx_q;
        case (state_q)
            IDLE: begin
                if (|miss) begin
                    mtag_d  = pick_tag;
                    vtag_d  = pick_vtag;
                    midx_d  = pick_idx;
                    state_d = pick_wb ? WB : FILL;
                end
            end
            WB:      if (mem_ack) state_d = FILL;
            FILL:    if (mem_ack) state_d = REFILL;
            REFILL:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            mtag_q  <= mtag_d;
            vtag_q  <= vtag_d;
            midx_q  <= midx_d;
            if (fill_done) miss_cnt_q <= miss_cnt_q + 1'b1;
            if (!stall)    hit_cnt_q  <= hit_cnt_q + CNT_W'($countones(hit));
        end
    end

    // Ascending slot order lets the youngest writer to a word win.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            data_q[midx_q] <= mem_rline;
        end else if (!stall) begin
            for (int p = 0; p < NPORTS; p++)
                if (we[p] & hit[p])
                    data_q[s_idx[p]][s_off[p]*DATA_W +: DATA_W] <= wdata[p*DATA_W +: DATA_W];
        end
    end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl with a 5-cycle-latency line memory model.
module tb_cache_mem_ctrl;

    localparam int LAT = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   re, we;
    logic [63:0]  addr, wdata;
    logic [63:0]  rdata;
    logic [1:0]   hit, miss;
    logic         stall, mem_req, mem_we, mem_ack;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wline, mem_rline;
    logic [31:0]  hit_cnt, miss_cnt;

    int tests = 0;
    int fails = 0;

    logic         model_en;
    int           wcnt;
    logic [127:0] mem_m [logic [31:0]];
    logic [31:0]  fill_log [$];

    cache_mem_ctrl dut (
        .clk       (clk),
        .reset     (rst),
        .re        (re),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .hit       (hit),
        .miss      (miss),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wline (mem_wline),
        .mem_ack   (mem_ack),
        .mem_rline (mem_rline),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    // Memory model: acks on the LAT-th cycle a request is seen, one-cycle strobe.
    always @(negedge clk) begin
        if (model_en) begin
            if (mem_ack) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else if (mem_req) begin
                wcnt++;
                if (wcnt == LAT) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem_m[mem_addr] = mem_wline;
                    end else begin
                        mem_rline = mem_m.exists(mem_addr) ? mem_m[mem_addr] : 128'd0;
                        fill_log.push_back(mem_addr);
                    end
                end
            end
        end else begin
            wcnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_unstall(input string tag);
        int n;
        n = 0;
        while (stall && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {127'd0, stall}, 128'd0);
    endtask

    initial begin
        int n;
        int stall_seen;
        rst = 1'b1; re = '0; we = '0; addr = '0; wdata = '0;
        mem_ack = 1'b0; mem_rline = '0; model_en = 1'b1; wcnt = 0;
        mem_m[32'h100]  = {64'd0, 32'h1234_5678, 32'hDEAD_BEEF};
        mem_m[32'h1100] = {96'd0, 32'hCAFE_0001};
        mem_m[32'h200]  = {96'd0, 32'hA0A0_A0A0};
        mem_m[32'h300]  = {64'd0, 32'hB1B1_B1B1, 32'd0};
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", {127'd0, stall}, 128'd0);
        chk("rst_req", {127'd0, mem_req}, 128'd0);
        chk("rst_hitcnt", {96'd0, hit_cnt}, 128'd0);
        chk("rst_misscnt", {96'd0, miss_cnt}, 128'd0);

        // 1: cold read miss, fill, then hit
        step();
        re = 2'b01; addr[31:0] = 32'h100;
        @(negedge clk);
        chk("t1_miss", {126'd0, miss}, 128'd1);
        n = 0;
        while (stall && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("t1_stall_cycles", 128'(n), 128'd7);
        chk("t1_hit", {126'd0, hit}, 128'd1);
        chk("t1_rdata", {96'd0, rdata[31:0]}, 128'hDEAD_BEEF);
        chk("t1_misscnt", {96'd0, miss_cnt}, 128'd1);

        // 2: same-word writes, youngest wins; read sees old data on same-cycle write
        step();
        re = 2'b00; we = 2'b11; addr = {32'h100, 32'h100}; wdata = {32'h22, 32'h11};
        @(negedge clk);
        chk("t2_hit_both", {126'd0, hit}, 128'd3);
        chk("t2_nostall", {127'd0, stall}, 128'd0);
        step();
        we = 2'b00; re = 2'b01;
        @(negedge clk);
        chk("t2_youngest", {96'd0, rdata[31:0]}, 128'h22);
        step();
        re = 2'b01; we = 2'b10; wdata[63:32] = 32'h33;
        @(negedge clk);
        chk("t2_read_old", {96'd0, rdata[31:0]}, 128'h22);
        step();
        re = 2'b11; we = 2'b00; addr = {32'h104, 32'h100};
        @(negedge clk);
        chk("t2_read_new", {96'd0, rdata[31:0]}, 128'h33);
        chk("t2_word1", {96'd0, rdata[63:32]}, 128'h1234_5678);

        // 3: dirty eviction -> writeback of old line then fill
        step();
        re = 2'b01; addr[31:0] = 32'h1100;
        @(negedge clk);
        chk("t3_miss", {126'd0, miss}, 128'd1);
        chk("t3_hitcnt", {96'd0, hit_cnt}, 128'd8);
        n = 0;
        while (!(mem_req && mem_we) && n < 50) begin @(negedge clk); n++; end
        chk("t3_wb_seen", {127'd0, mem_req & mem_we}, 128'd1);
        chk("t3_wb_addr", {96'd0, mem_addr}, 128'h100);
        chk("t3_wb_line", mem_wline, {64'd0, 32'h1234_5678, 32'h33});
        n = 0;
        while (!(mem_req && !mem_we) && n < 50) begin @(negedge clk); n++; end
        chk("t3_fill_addr", {96'd0, mem_addr}, 128'h1100);
        wait_unstall("t3_unstall");
        chk("t3_rdata", {96'd0, rdata[31:0]}, 128'hCAFE_0001);
        chk("t3_misscnt", {96'd0, miss_cnt}, 128'd2);
        chk("t3_mem_old", mem_m[32'h100], {64'd0, 32'h1234_5678, 32'h33});

        // 4: both slots miss different sets; slot 0 serviced first
        step();
        fill_log.delete();
        re = 2'b11; addr = {32'h304, 32'h200};
        @(negedge clk);
        chk("t4_miss", {126'd0, miss}, 128'd3);
        wait_unstall("t4_unstall");
        chk("t4_nfills", 128'(fill_log.size()), 128'd2);
        if (fill_log.size() == 2) begin
            chk("t4_first", {96'd0, fill_log[0]}, 128'h200);
            chk("t4_second", {96'd0, fill_log[1]}, 128'h300);
        end
        chk("t4_misscnt", {96'd0, miss_cnt}, 128'd4);
        chk("t4_hit", {126'd0, hit}, 128'd3);
        chk("t4_rdata", {64'd0, rdata}, {64'd0, 32'hB1B1_B1B1, 32'hA0A0_A0A0});

        // 5: reset during FILL abandons the transaction; late ack ignored
        step();
        model_en = 1'b0;
        re = 2'b01; addr = {32'h0, 32'h400};
        @(negedge clk);
        chk("t5_miss", {126'd0, miss}, 128'd1);
        step();
        @(negedge clk);
        chk("t5_fill_req", {126'd0, mem_req, mem_we}, 128'd2);
        step();
        rst = 1'b1; re = 2'b00;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_req_dropped", {127'd0, mem_req}, 128'd0);
        mem_ack = 1'b1; mem_rline = {4{32'h5555_5555}};
        step();
        mem_ack = 1'b0;
        re = 2'b01;
        @(negedge clk);
        chk("t5_still_invalid", {126'd0, hit, miss}, 128'b0001);
        chk("t5_misscnt", {96'd0, miss_cnt}, 128'd0);
        chk("t5_hitcnt", {96'd0, hit_cnt}, 128'd0);
        step();
        rst = 1'b1; re = 2'b00;
        step();
        rst = 1'b0; model_en = 1'b1;

        // 6: 100 consecutive dual hits after warming two lines
        re = 2'b11; addr = {32'h304, 32'h200};
        @(negedge clk);
        wait_unstall("t6_warm");
        stall_seen = 0;
        for (int i = 1; i < 100; i++) begin
            step();
            @(negedge clk);
            if (stall) stall_seen++;
        end
        step();
        re = 2'b00;
        @(negedge clk);
        chk("t6_hitcnt", {96'd0, hit_cnt}, 128'd200);
        chk("t6_no_stall", 128'(stall_seen), 128'd0);
        chk("t6_misscnt", {96'd0, miss_cnt}, 128'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
